// File: rtl/add_round_key_16.sv
// Round-key addition stage: expands a 16-bit key into NUM_ROUNDS+1 round keys and
// XORs the selected one into each state word. Optional feature macro: ARK_ROUND_CHECK_EN.
module add_round_key_16 #(
    parameter int NUM_ROUNDS = 2,
    parameter int RIDX_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load,
    input  logic [15:0]       key_in,
    output logic              key_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RIDX_W-1:0] in_round,
    input  logic [15:0]       data_in,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef ARK_ROUND_CHECK_EN
    output logic [15:0]       data_out,
    output logic              err_out
`else
    output logic [15:0]       data_out
`endif
);

    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS);
    localparam logic [RIDX_W-1:0] ONE_IDX  = RIDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [15:0]       key_r [0:NUM_ROUNDS];
    logic [RIDX_W-1:0] rcnt_r;
    logic [3:0]        rcon_r;
    logic [15:0]       next_key_s;
    logic [RIDX_W-1:0] sel_idx_s;
    logic              xfer_s;
    logic              bad_round_s;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hD;  4'h3: y = 4'h1;
            4'h4: y = 4'h2;  4'h5: y = 4'hF;  4'h6: y = 4'hB;  4'h7: y = 4'h8;
            4'h8: y = 4'h3;  4'h9: y = 4'hA;  4'hA: y = 4'h6;  4'hB: y = 4'hC;
            4'hC: y = 4'h5;  4'hD: y = 4'h9;  4'hE: y = 4'h0;  4'hF: y = 4'h7;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // Multiply by x modulo x^4+x+1.
    function automatic logic [3:0] gf_mul2(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [15:0] round_key_next(input logic [15:0] prev, input logic [3:0] rcon);
        logic [3:0] w4, w5, w6, w7;
        w4 = prev[15:12] ^ sbox(prev[3:0]) ^ rcon;
        w5 = prev[11:8] ^ w4;
        w6 = prev[7:4] ^ w5;
        w7 = prev[3:0] ^ w6;
        return {w4, w5, w6, w7};
    endfunction

    assign key_ready   = (state_r == ST_READY);
    assign in_ready    = key_ready && (!out_valid || out_ready);
    assign xfer_s      = in_valid && in_ready;
    assign bad_round_s = (in_round > LAST_IDX);

    // Round-key derivation and index clamping.
    always_comb begin
        next_key_s = round_key_next(key_r[rcnt_r - ONE_IDX], rcon_r);
        if (bad_round_s) begin
            sel_idx_s = LAST_IDX;
        end else begin
            sel_idx_s = in_round;
        end
    end

    // Next-state logic for the key-expansion FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (key_load) state_s = ST_EXPAND;
                else          state_s = ST_IDLE;
            end
            ST_EXPAND: begin
                if (key_load)                 state_s = ST_EXPAND;
                else if (rcnt_r == LAST_IDX)  state_s = ST_READY;
                else                          state_s = ST_EXPAND;
            end
            ST_READY: begin
                if (key_load) state_s = ST_EXPAND;
                else          state_s = ST_READY;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Key store: K0 on load, then one derived key per EXPAND cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                key_r[i] <= 16'h0000;
            end
            rcnt_r <= '0;
            rcon_r <= 4'h0;
        end else if (key_load) begin
            key_r[0] <= key_in;
            rcnt_r   <= ONE_IDX;
            rcon_r   <= 4'h1;
        end else if (state_r == ST_EXPAND) begin
            key_r[rcnt_r] <= next_key_s;
            rcnt_r        <= rcnt_r + ONE_IDX;
            rcon_r        <= gf_mul2(rcon_r);
        end else begin
            rcnt_r <= rcnt_r;
            rcon_r <= rcon_r;
        end
    end

    // Output register with valid/ready handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= 16'h0000;
`ifdef ARK_ROUND_CHECK_EN
            err_out   <= 1'b0;
`endif
        end else if (xfer_s) begin
            out_valid <= 1'b1;
`ifdef ARK_ROUND_CHECK_EN
            if (bad_round_s) begin
                data_out <= 16'h0000;
                err_out  <= 1'b1;
            end else begin
                data_out <= data_in ^ key_r[sel_idx_s];
                err_out  <= 1'b0;
            end
`else
            data_out  <= data_in ^ key_r[sel_idx_s];
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_add_round_key_16.sv
// Self-checking bench for add_round_key_16: directed scenarios, then random traffic
// compared against a word-array key-schedule model.
module tb_add_round_key_16;

    localparam int NR = 2;

    logic        clk = 1'b0;
    logic        rst, key_load, key_ready, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] key_in, data_in, data_out;
    logic [1:0]  in_round;
`ifdef ARK_ROUND_CHECK_EN
    logic        err_out;
`endif

    always #5 clk = ~clk;

    add_round_key_16 #(.NUM_ROUNDS(NR), .RIDX_W(2)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .key_ready(key_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_round(in_round), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef ARK_ROUND_CHECK_EN
        .data_out(data_out), .err_out(err_out)
`else
        .data_out(data_out)
`endif
    );

    int sbox_tab [16] = '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7};

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [15:0] m_keys [0:NR];
    int          m_cnt;
    bit          m_busy, m_kready, m_ov, m_err;
    logic [15:0] m_dout;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Carry-less product reduced by x^4+x+1 (0x13).
    function automatic int gf_mul(input int a, input int b);
        int p = 0;
        for (int i = 0; i < 4; i++) if ((b >> i) & 1) p ^= (a << i);
        for (int bitp = 7; bitp >= 4; bitp--) if ((p >> bitp) & 1) p ^= (19 << (bitp - 4));
        return p & 15;
    endfunction

    function automatic void expand(input logic [15:0] key);
        int w [4*(NR+1)];
        int rc = 1;
        for (int j = 0; j < 4; j++) w[j] = (key >> (12 - 4*j)) & 15;
        for (int i = 4; i < 4*(NR+1); i++) begin
            if (i % 4 == 0) begin
                w[i] = w[i-4] ^ sbox_tab[w[i-1]] ^ rc;
                rc   = gf_mul(rc, 2);
            end else begin
                w[i] = w[i-4] ^ w[i-1];
            end
        end
        for (int r = 0; r <= NR; r++)
            m_keys[r] = 16'((w[4*r] << 12) | (w[4*r+1] << 8) | (w[4*r+2] << 4) | w[4*r+3]);
    endfunction

    task automatic step(input bit r, input bit kl, input logic [15:0] k, input bit iv,
                        input logic [1:0] rnd, input logic [15:0] din, input bit ordy);
        bit exp_ir;
        int idx;
        rst = r; key_load = kl; key_in = k; in_valid = iv; in_round = rnd;
        data_in = din; out_ready = ordy;
        #1;
        exp_ir = m_kready && (!m_ov || ordy);
        check_val("in_ready", 16'(in_ready), 16'(exp_ir));
        @(posedge clk);
        if (r) begin
            m_busy = 0; m_kready = 0; m_ov = 0; m_err = 0; m_dout = 16'h0000; m_cnt = 0;
        end else begin
            if (iv && exp_ir) begin
                idx = (int'(rnd) > NR) ? NR : int'(rnd);
                m_ov = 1;
`ifdef ARK_ROUND_CHECK_EN
                m_err  = (int'(rnd) > NR);
                m_dout = m_err ? 16'h0000 : (din ^ m_keys[idx]);
`else
                m_dout = din ^ m_keys[idx];
`endif
            end else if (m_ov && ordy) begin
                m_ov = 0;
            end
            if (kl) begin
                expand(k); m_busy = 1; m_cnt = 0; m_kready = 0;
            end else if (m_busy) begin
                m_cnt++;
                if (m_cnt == NR) begin
                    m_busy = 0; m_kready = 1;
                end
            end
        end
        @(negedge clk);
        check_val("out_valid", 16'(out_valid), 16'(m_ov));
        check_val("data_out", data_out, m_dout);
        check_val("key_ready", 16'(key_ready), 16'(m_kready));
`ifdef ARK_ROUND_CHECK_EN
        check_val("err_out", 16'(err_out), 16'(m_err));
`endif
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, ordy);
    endtask

    logic [15:0] held;

    initial begin
        rst = 1'b1; key_load = 1'b0; key_in = 16'h0000; in_valid = 1'b0;
        in_round = 2'd0; data_in = 16'h0000; out_ready = 1'b0;
        m_busy = 0; m_kready = 0; m_ov = 0; m_err = 0; m_dout = 16'h0000; m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1);
        check_val("rst_data_out", data_out, 16'h0000);
        idle(1'b1);

        // Key C3F0 and the three-round data vectors.
        step(1'b0, 1'b1, 16'hC3F0, 1'b0, 2'd0, 16'h0000, 1'b1);
        idle(1'b1);
        check_val("kready_early", 16'(key_ready), 16'h0000);
        idle(1'b1);
        check_val("kready_2cyc", 16'(key_ready), 16'h0001);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd0, 16'h1234, 1'b1);
        check_val("vec_d1c4", data_out, 16'hD1C4);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 16'h1234, 1'b1);
        check_val("vec_22cb", data_out, 16'h22CB);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd2, 16'h1234, 1'b1);
        check_val("vec_74a2", data_out, 16'h74A2);
        idle(1'b1);

        // Stall for five cycles, then release with a new word waiting.
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd1, 16'hBEEF, 1'b0);
        held = data_out;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd2, 16'h5555, 1'b0);
            check_val("stall_hold", data_out, held);
        end
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd2, 16'h5555, 1'b1);
        check_val("release_accept", 16'(out_valid), 16'h0001);
        idle(1'b1);

        // Key reload while a word is pending; then key 0000 vectors.
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd0, 16'h0F0F, 1'b0);
        held = data_out;
        step(1'b0, 1'b1, 16'h0000, 1'b1, 2'd0, 16'h7777, 1'b0);
        check_val("pending_kept", data_out, held);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd0, 16'h7777, 1'b1);
        idle(1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd2, 16'h0000, 1'b1);
        check_val("vec_a5a5", data_out, 16'hA5A5);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd3, 16'h1234, 1'b1);
`ifdef ARK_ROUND_CHECK_EN
        check_val("oor_zero", data_out, 16'h0000);
        check_val("oor_err", 16'(err_out), 16'h0001);
`else
        check_val("oor_clamp", data_out, 16'hB791);
`endif
        step(1'b0, 1'b0, 16'h0000, 1'b1, 2'd3, 16'h4321, 1'b0);

        // Reset in the middle of an expansion with a word pending.
        step(1'b0, 1'b1, 16'h9A3C, 1'b0, 2'd0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0);
        check_val("rst_mid_kready", 16'(key_ready), 16'h0000);
        check_val("rst_mid_ovalid", 16'(out_valid), 16'h0000);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0), 16'($urandom),
                 ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 16'($urandom),
                 ($urandom_range(0, 9) < 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/add_round_key_16.md
Name: add_round_key_16

Overview:
- Round-key addition stage of the 16-bit nibble-oriented cipher core; sits directly downstream of the 16-bit mix-columns stage and consumes its output word.
- Holds a 16-bit cipher key, expands it on-chip into NUM_ROUNDS+1 round keys (4-bit S-box, GF(2^4) with polynomial x^4+x+1), and XORs the selected round key into each incoming state word.
- Valid/ready handshake on both sides, one registered output stage.

Parameters:
- NUM_ROUNDS, 2, number of expanded round keys after K0; legal range 1..(2^RIDX_W)-1.
- RIDX_W, 2, width of the round-index field.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_load  input  1  start key expansion using key_in; one-cycle pulse.
- key_in  input  16  cipher key; nibbles w0..w3 = [15:12]..[3:0].
- key_ready  output  1  round-key store valid; expansion complete.
- in_valid  input  1  state word present.
- in_ready  output  1  stage accepts a word.
- in_round  input  RIDX_W  round-key index to apply.
- data_in  input  16  state word from mix-columns.
- out_valid  output  1  data_out valid.
- out_ready  input  1  downstream accepts.
- data_out  output  16  data_in XOR selected round key.

Behaviour:
- Reset, sampled at a rising edge with rst=1: FSM=IDLE, key store cleared to 0, key_ready=0, out_valid=0, data_out=16'h0000, in_ready=0.
- FSM has three states:
  - IDLE: no valid keys. key_load -> EXPAND.
  - EXPAND: builds the round keys; leaves after NUM_ROUNDS cycles.
  - READY: keys valid. key_load -> EXPAND.
- Key load and expansion timing:
  - key_load sampled at edge T: K0 <= key_in, rcnt <= 1, rcon <= 4'h1, FSM -> EXPAND.
  - Edges T+1..T+NUM_ROUNDS write K1..K_NUM_ROUNDS, one per cycle, computed from the previous key:
    - w4 = w0 ^ S(w3) ^ rcon
    - w5 = w1 ^ w4
    - w6 = w2 ^ w5
    - w7 = w3 ^ w6
    - Then rcon <= gf_mul_2(rcon), giving the sequence 1, 2, 4, 8, 3, ...
  - At edge T+NUM_ROUNDS FSM -> READY; key_ready = (FSM==READY).
- S-box, inputs 0..F map to: E 4 D 1 2 F B 8 3 A 6 C 5 9 0 7.
- key_load in EXPAND or READY restarts the expansion from the new key_in. key_ready drops in the following cycle.
- in_ready = key_ready && (!out_valid || out_ready). This is combinational; no combinational path from in_valid to in_ready.
- Input transfer (in_valid && in_ready at an edge) registers:
  - data_out <= data_in ^ K[in_round]
  - out_valid <= 1
  - Latency is 1 cycle.
- Output register:
  - out_valid && out_ready with no new transfer: out_valid <= 0.
  - Simultaneous output accept and new input: out_valid stays 1 and data_out updates (full throughput, one word per cycle).
- Stall: out_valid && !out_ready holds data_out and out_valid stable; in_ready=0.
- An output word already registered when key_load arrives is kept and must still be delivered. No input is accepted until key_ready=1 again.
- Out-of-range in_round (> NUM_ROUNDS), default build: index clamps to NUM_ROUNDS.
- rst mid-expansion or mid-stall: everything returns to reset values; the pending output word is discarded.

Optional Feature:
- Macro ARK_ROUND_CHECK_EN.
- Defined: adds output port err_out (1 bit, registered, resets to 0).
  - A transfer with in_round > NUM_ROUNDS produces data_out=16'h0000 and err_out=1 for that beat.
  - err_out follows out_valid timing and clears on the next transfer with a legal in_round.
- Undefined: no err_out port; out-of-range indices clamp to NUM_ROUNDS as above.

Test Plan:
- Reset then key_load with key_in=16'hC3F0 -> key_ready rises 2 cycles after the load edge; internal K0=C3F0, K1=30FF, K2=6696.
- After the key above, data_in=16'h1234 with in_round 0, 1, 2 on back-to-back cycles, out_ready=1 -> data_out D1C4, 22CB, 74A2 on consecutive cycles, one cycle after each input.
- key_in=16'h0000 -> K1=FFFF, K2=A5A5; data_in=16'h0000, in_round=2 -> data_out=A5A5.
- Hold out_ready=0 with a word pending -> in_ready=0 and data_out stable for 5 cycles; release -> word delivered and the next input accepted the same cycle.
- key_load while a word is pending -> pending word still delivered unchanged; in_ready=0 until the new key_ready; a new word uses the new keys.
- in_round=3 with NUM_ROUNDS=2:
  - without ARK_ROUND_CHECK_EN: data_out = data_in ^ K2;
  - with it: data_out=0000 and err_out=1.
  - rst asserted mid-EXPAND -> key_ready=0 and out_valid=0 next cycle.
